// File: rtl/vmem_pkg.sv
// Shared types and defaults for the video-memory arbiter.
package vmem_pkg;

    localparam int unsigned ADDR_W_DEF = 19;
    localparam int unsigned DATA_W_DEF = 24;

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    // Which requester owns the memory command slot this cycle
    typedef enum logic [2:0] {
        SelNone,
        SelVga,
        SelClr,
        SelWr0,
        SelWr1
    } sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// Under contention, the writer that was not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = req;
            endcase
        end
        last_d = last_q;
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    // last = 1 out of reset so writer 0 wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads first, then the clear
// sequencer, then two round-robin pixel writers.
module vmem_arbiter
    import vmem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              wr0_valid,
    output logic              wr0_ready,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_valid,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    sel_e              sel;
    logic [1:0]        wr_gnt;
    logic              arb_en;
    logic              clr_last;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]        rd_pipe_q;
    logic              vga_rvalid_q;
    logic [DATA_W-1:0] vga_rdata_q;
    logic              clr_done_q;

    // Writers only compete for cycles left idle by scan-out and the clear
    assign arb_en   = (state_q == StIdle) && !vga_req;
    assign clr_last = &cnt_q;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({wr1_valid, wr0_valid}),
        .gnt (wr_gnt)
    );

    always_comb begin
        sel = SelNone;
        if (vga_req) begin
            sel = SelVga;
        end else if (state_q == StClear) begin
            sel = SelClr;
        end else if (wr_gnt[0]) begin
            sel = SelWr0;
        end else if (wr_gnt[1]) begin
            sel = SelWr1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (sel == SelClr) begin
                    cnt_d = cnt_q + 1'b1;
                    if (clr_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en_d    = (sel != SelNone);
        mem_we_d    = sel inside {SelClr, SelWr0, SelWr1};
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (sel)
            SelVga: mem_addr_d = vga_addr;
            SelClr: begin
                mem_addr_d  = cnt_q;
                mem_wdata_d = CLEAR_COLOR;
            end
            SelWr0: begin
                mem_addr_d  = wr0_addr;
                mem_wdata_d = wr0_data;
            end
            SelWr1: begin
                mem_addr_d  = wr1_addr;
                mem_wdata_d = wr1_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_pipe_q    <= 2'b00;
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            clr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            // Stage 0: command issued, stage 1: RAM data present
            rd_pipe_q    <= {rd_pipe_q[0], sel == SelVga};
            vga_rvalid_q <= rd_pipe_q[1];
            if (rd_pipe_q[1]) begin
                vga_rdata_q <= mem_rdata;
            end
            clr_done_q   <= (sel == SelClr) && clr_last;
        end
    end

    assign wr0_ready  = wr_gnt[0];
    assign wr1_ready  = wr_gnt[1];
    assign clr_busy   = (state_q == StClear);
    assign clr_done   = clr_done_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rdata_q;

endmodule

// File: doc/vmem_arbiter.md
# vmem_arbiter

Shares the single-port video memory between VGA scan-out reads, two pixel-write requesters and a built-in screen-clear sequencer. It sits between the VGA controller (pixel address `{h_addr, v_addr[8:0]}`) and the frame-buffer RAM, replacing the direct combinational read path. Scan-out reads always win. Writers share the remaining cycles round-robin and are blocked while a clear is in progress.

## Interface
- `ADDR_W`, 19: memory address width; depth is 2^ADDR_W.
- `DATA_W`, 24: pixel width (RGB888).
- `CLEAR_COLOR`, 24'h000000: fill value written by the clear sequencer.

- `clk`  in  1: single clock for all logic.
- `rst`  in  1: reset; synchronous, active-high.
- `vga_req`  in  1: scan-out read request for this cycle.
- `vga_addr`  in  ADDR_W: read address, `{h_addr, v_addr[8:0]}`.
- `vga_rdata`  out  DATA_W: registered read data.
- `vga_rvalid`  out  1: `vga_rdata` is updated this cycle.
- `wr0_valid`, `wr1_valid`  in  1: write request.
- `wr0_ready`, `wr1_ready`  out  1: write accepted this cycle.
- `wr0_addr`, `wr1_addr`  in  ADDR_W: write address.
- `wr0_data`, `wr1_data`  in  DATA_W: write data.
- `clr_start`  in  1: pulse to start a full-memory fill.
- `clr_busy`  out  1: clear in progress.
- `clr_done`  out  1: one-cycle pulse when the clear finishes.
- `mem_en`, `mem_we`  out  1: registered RAM command.
- `mem_addr`  out  ADDR_W: registered RAM address.
- `mem_wdata`  out  DATA_W: registered RAM write data.
- `mem_rdata`  in  DATA_W: RAM read data, valid one cycle after the read command.

## Operation
- **Arbitration** is decided each cycle. Priority order:
  - `vga_req`;
  - the clear sequencer, when in state CLEAR;
  - the writers, round-robin, only in state IDLE.
- **Write handshake.** A transfer occurs when `wrN_valid && wrN_ready`.
  - `wrN_ready` is combinational and may depend on `wrN_valid`.
  - A requester holds its address and data stable until accepted.
- **Round-robin rule.** A pointer `last` records the writer that was last granted.
  - When both writers are valid, the grant goes to the writer that is not `last`.
  - `last` updates only on a grant.
  - Reset sets `last` = 1, so writer 0 wins the first contention.
- **State machine.**
  - IDLE → CLEAR on `clr_start`. This clears the counter to 0; `clr_busy` is high from the next cycle.
  - In CLEAR, every cycle without `vga_req` writes `CLEAR_COLOR` at the counter address, then increments the counter.
  - CLEAR → IDLE after the write to address 2^ADDR_W−1 is issued. `clr_done` pulses on the cycle the state returns to IDLE.
  - `clr_start` while in CLEAR is ignored.
- **Idle cycles.** With no grant, `mem_en` = 0 and `mem_we` = 0. `mem_addr` and `mem_wdata` hold their previous values.
- **Read data.** `vga_rdata` holds its value between reads.
- **Reset values** for all outputs are 0, state is IDLE and the counter is 0. Reset mid-clear aborts the clear without a `clr_done` pulse. Any read still in flight produces no `vga_rvalid`.

## Timing
- **Read latency** is 3 cycles:
  - cycle N: `vga_req` is sampled;
  - N+1: `mem_en`=1, `mem_we`=0, `mem_addr`=`vga_addr`;
  - N+2: `mem_rdata` is valid;
  - N+3: `vga_rdata` and `vga_rvalid`=1.
- Back-to-back reads are fully pipelined, one per cycle.
- **Write.** Accepted at cycle N; `mem_en`=`mem_we`=1 with address and data at N+1.
- **Simultaneous events.**
  - `vga_req` together with a valid writer: both writer readies stay 0 and the writer stalls. Writer starvation under continuous `vga_req` is allowed; blanking intervals provide the write slots.
  - `clr_start` together with a writer valid in IDLE: the writer is granted in that cycle, and CLEAR begins the next cycle.
- **Clear duration** is 2^ADDR_W write slots plus any cycles stolen by `vga_req`.

## Structure
- Package `vmem_pkg` holds:
  - the `ADDR_W` and `DATA_W` defaults;
  - the state enum (IDLE, CLEAR);
  - the grant-select encoding (NONE, VGA, CLR, WR0, WR1).
- Sub-module `rr_arb2` is the two-requester round-robin arbiter with the `last` pointer. It takes a global enable and produces a one-hot grant.
- The top level contains the FSM, clear counter, command registers and read-return pipeline.

## Test plan
- **Read pipeline.** Preload mem[5] = 24'hABCDEF and pulse `vga_req` with `vga_addr`=5 at cycle 10. Expect `vga_rdata`=24'hABCDEF with `vga_rvalid` at cycle 13 and no other `vga_rvalid`.
- **Read priority.** Hold `wr0_valid` (addr 7, data 24'h112233) while `vga_req`=1 for 4 cycles. Expect `wr0_ready`=0 for those 4 cycles, acceptance on the first cycle `vga_req`=0, and `mem_we` with addr 7 one cycle later.
- **Round-robin.** Hold both writers valid continuously after reset. Expect grants in the order wr0, wr1, wr0, wr1, with exactly one ready high per cycle.
- **Clear.** Use `ADDR_W`=4 and `CLEAR_COLOR`=24'h0000FF, pulse `clr_start`, and insert a `vga_req` every 3rd cycle.
  - Expect 16 writes of 24'h0000FF covering addresses 0..15 in order.
  - Expect writer readies to stay 0 throughout and a single `clr_done` pulse.
- **Reset mid-clear.** Assert `rst` after 5 clear writes. Expect `clr_busy`=0, no `clr_done`, and the next `clr_start` to restart the fill at address 0.
- **Start collision.** Assert `clr_start` together with `wr1_valid` in IDLE. Expect the wr1 write to be issued, followed by clear writes starting at address 0 on the following cycles.
